eth_rx_payload: RTL and testbench

Frame-committed receive buffer between the Ethernet receive MAC byte stream and the packet handler's read port. Bytes of each incoming frame are written into a circular buffer. A frame becomes visible to the reader only after its last byte arrives clean; errored, runt, oversize and overflowing frames are discarded. The read side is a first-word-fall-through byte port: data is valid whenever ready is high. Between frames the port is held idle for a guaranteed gap, so a reader that uses silence to detect end-of-frame sees one frame at a time.

---
 rtl/eth_rx_payload.sv | 131 +++++++++++++
 tb/tb_eth_rx_payload.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_payload.sv
// Frame-committed receive buffer: MAC bytes are staged in a circular buffer and
// exposed to the first-word-fall-through read port only once the frame ends clean.
//
// state   | meaning
// W_IDLE  | waiting for a start-of-frame byte
// W_FRAME | storing bytes of the current frame tentatively
// W_DROP  | discarding the rest of an overflowed frame until eof
module eth_rx_payload #(
  parameter int DEPTH_LOG2 = 10,
  parameter int MIN_LEN    = 1,
  parameter int MAX_LEN    = 1500,
  parameter int FRAME_GAP  = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_sof,
  input  logic        i_rx_eof,
  input  logic        i_rx_err,
  output logic [7:0]  o_rdata,
  output logic        o_rlast,
  output logic        o_rready,
  input  logic        i_rreq,
  output logic [15:0] o_rx_frames,
  output logic [15:0] o_rx_drops,
  output logic        o_overflow
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  localparam logic [15:0] GAP_L = 16'(FRAME_GAP);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_FRAME = 2'd1;
  localparam logic [1:0] W_DROP  = 2'd2;

  logic [8:0]    mem [0:(1<<DEPTH_LOG2)-1];
  logic [PW-1:0] rd_ptr, wr_ptr, cm_ptr;
  logic [1:0]    state;
  logic [10:0]   len;
  logic [15:0]   gap_cnt;

  logic          start, cont, accept, blocked, abort, do_write, do_commit, bad_eof, pop;
  logic [PW-1:0] base, wr_next;
  logic [10:0]   len_next;
  logic [1:0]    drop_inc;
  logic [16:0]   drop_sum;
  logic [8:0]    head;

  // A start byte always lands at cm_ptr, so a mid-frame sof both discards the
  // partial frame and reuses its space in the same cycle.
  always_comb begin
    start     = i_rx_valid & i_rx_sof;
    cont      = i_rx_valid & ~i_rx_sof & (state == W_FRAME);
    accept    = start | cont;
    abort     = start & (state == W_FRAME);
    base      = start ? cm_ptr : wr_ptr;
    blocked   = accept & ((base - rd_ptr) == DEPTH_P);
    do_write  = accept & ~blocked;
    wr_next   = base + 1'b1;
    if (start)
      len_next = 11'd1;
    else if (len == 11'h7FF)
      len_next = len;
    else
      len_next = len + 11'd1;
    do_commit = do_write & i_rx_eof & ~i_rx_err & (len_next >= MIN_L) & (len_next <= MAX_L);
    bad_eof   = do_write & i_rx_eof & ~do_commit;
    drop_inc  = {1'b0, abort} + {1'b0, blocked} + {1'b0, bad_eof};
    drop_sum  = {1'b0, o_rx_drops} + {15'd0, drop_inc};
    head      = mem[rd_ptr[DEPTH_LOG2-1:0]];
    o_rready  = (rd_ptr != cm_ptr) && (gap_cnt == 16'd0);
    pop       = i_rreq & o_rready;
  end

  assign o_rdata = head[7:0];
  assign o_rlast = head[8];

  always_ff @(posedge i_clk) begin
    if (do_write)
      mem[base[DEPTH_LOG2-1:0]] <= {i_rx_eof, i_rx_data};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= W_IDLE;
      wr_ptr      <= '0;
      cm_ptr      <= '0;
      len         <= '0;
      o_rx_frames <= '0;
      o_rx_drops  <= '0;
      o_overflow  <= 1'b0;
    end else begin
      o_overflow <= blocked;
      o_rx_drops <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (do_write) begin
        len    <= len_next;
        wr_ptr <= bad_eof ? cm_ptr : wr_next;
        state  <= i_rx_eof ? W_IDLE : W_FRAME;
        if (do_commit) begin
          cm_ptr      <= wr_next;
          o_rx_frames <= o_rx_frames + 16'd1;
        end
      end else if (blocked) begin
        wr_ptr <= cm_ptr;
        state  <= i_rx_eof ? W_IDLE : W_DROP;
      end else if (i_rx_valid && i_rx_eof && state == W_DROP) begin
        state <= W_IDLE;
      end
    end
  end

  // Popping a last byte opens the inter-frame gap; nothing pops while it runs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr  <= '0;
      gap_cnt <= '0;
    end else begin
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (pop && head[8])
        gap_cnt <= GAP_L;
      else if (gap_cnt != 16'd0)
        gap_cnt <= gap_cnt - 16'd1;
    end
  end

endmodule

// File: tb/tb_eth_rx_payload.sv
// Directed bench for eth_rx_payload: a large-buffer instance for the main
// frame/gap/error/length/reset cases and a 16-entry instance for overflow.
module tb_eth_rx_payload;

  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  logic [7:0]  m_data, s_data;
  logic        m_valid, m_sof, m_eof, m_err, m_rreq;
  logic        s_valid, s_sof, s_eof, s_err, s_rreq;
  logic [7:0]  m_rdata, s_rdata;
  logic        m_rlast, s_rlast, m_rready, s_rready, m_ov, s_ov;
  logic [15:0] m_frames, s_frames, m_drops, s_drops;

  int checks = 0;
  int failures = 0;
  int ov_seen = 0;

  eth_rx_payload #(.DEPTH_LOG2(11)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rx_data(m_data), .i_rx_valid(m_valid), .i_rx_sof(m_sof),
    .i_rx_eof(m_eof), .i_rx_err(m_err),
    .o_rdata(m_rdata), .o_rlast(m_rlast), .o_rready(m_rready), .i_rreq(m_rreq),
    .o_rx_frames(m_frames), .o_rx_drops(m_drops), .o_overflow(m_ov)
  );

  eth_rx_payload #(.DEPTH_LOG2(4), .MAX_LEN(12), .FRAME_GAP(4)) dut_small (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rx_data(s_data), .i_rx_valid(s_valid), .i_rx_sof(s_sof),
    .i_rx_eof(s_eof), .i_rx_err(s_err),
    .o_rdata(s_rdata), .o_rlast(s_rlast), .o_rready(s_rready), .i_rreq(s_rreq),
    .o_rx_frames(s_frames), .o_rx_drops(s_drops), .o_overflow(s_ov)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (s_ov) ov_seen++;
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? s_rready : m_rready;
  endfunction

  function automatic logic [8:0] head(input bit sel);
    return sel ? {s_rlast, s_rdata} : {m_rlast, m_rdata};
  endfunction

  task automatic drv(input bit sel, input bit v, input bit sf, input bit ef, input bit er,
                     input logic [7:0] d);
    if (sel) begin
      s_valid = v; s_sof = sf; s_eof = ef; s_err = er; s_data = d;
    end else begin
      m_valid = v; m_sof = sf; m_eof = ef; m_err = er; m_data = d;
    end
  endtask

  task automatic set_rreq(input bit sel, input bit r);
    if (sel) s_rreq = r; else m_rreq = r;
  endtask

  task automatic send_frame(input bit sel, input int n, input int first, input bit err,
                            input bit with_eof);
    for (int i = 0; i < n; i++) begin
      drv(sel, 1'b1, i == 0, with_eof && i == n - 1, err && i == n - 1, 8'(first + i));
      tick();
    end
    drv(sel, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic read_frame(input bit sel, input int n, input int first, input string tag);
    int w;
    w = 0;
    while (!rdy(sel) && w < 200) begin
      tick();
      w++;
    end
    check_val({tag, "_ready"}, 32'(rdy(sel)), 32'd1);
    for (int i = 0; i < n; i++) begin
      check_val(tag, {23'd0, head(sel)}, {23'd0, 1'(i == n - 1), 8'(first + i)});
      set_rreq(sel, 1'b1);
      tick();
    end
    set_rreq(sel, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cnt;
    i_rst_n = 1'b0;
    drv(1'b0, 0, 0, 0, 0, 8'h00);
    drv(1'b1, 0, 0, 0, 0, 8'h00);
    m_rreq = 1'b0;
    s_rreq = 1'b0;
    idle(3);
    check_val("rst_ready", 32'(m_rready), 32'd0);
    check_val("rst_frames", 32'(m_frames), 32'd0);
    check_val("rst_drops", 32'(m_drops), 32'd0);
    check_val("rst_ovf", 32'(m_ov), 32'd0);
    i_rst_n = 1'b1;
    idle(2);

    // 10-byte frame visible the cycle after eof
    send_frame(1'b0, 10, 8'h01, 1'b0, 1'b1);
    check_val("t1_commit_latency", 32'(m_rready), 32'd1);
    read_frame(1'b0, 10, 8'h01, "t1_rd");
    check_val("t1_frames", 32'(m_frames), 32'd1);
    idle(70);

    // back-to-back frames, exact 64-cycle gap
    send_frame(1'b0, 5, 8'h11, 1'b0, 1'b1);
    send_frame(1'b0, 5, 8'h21, 1'b0, 1'b1);
    read_frame(1'b0, 5, 8'h11, "t2_rd_a");
    cnt = 0;
    while (!m_rready && cnt < 200) begin
      cnt++;
      tick();
    end
    check_val("t2_gap_len", 32'(cnt), 32'd64);
    read_frame(1'b0, 5, 8'h21, "t2_rd_b");
    check_val("t2_frames", 32'(m_frames), 32'd3);
    idle(70);

    // errored frame dropped, following good frame kept
    send_frame(1'b0, 6, 8'h31, 1'b1, 1'b1);
    check_val("t3_err_not_ready", 32'(m_rready), 32'd0);
    send_frame(1'b0, 4, 8'h41, 1'b0, 1'b1);
    check_val("t3_drops", 32'(m_drops), 32'd1);
    read_frame(1'b0, 4, 8'h41, "t3_rd");
    check_val("t3_frames", 32'(m_frames), 32'd4);
    idle(70);
    check_val("t3_empty", 32'(m_rready), 32'd0);

    // length boundary: 1500 kept, 1501 dropped, mid-frame sof drops partial
    send_frame(1'b0, 1500, 0, 1'b0, 1'b1);
    check_val("t5_max_frames", 32'(m_frames), 32'd5);
    read_frame(1'b0, 1500, 0, "t5_rd_max");
    idle(70);
    send_frame(1'b0, 1501, 0, 1'b0, 1'b1);
    check_val("t5_oversize_drops", 32'(m_drops), 32'd2);
    check_val("t5_oversize_not_ready", 32'(m_rready), 32'd0);
    send_frame(1'b0, 3, 8'hA1, 1'b0, 1'b0);
    send_frame(1'b0, 2, 8'h51, 1'b0, 1'b1);
    check_val("t5_drops", 32'(m_drops), 32'd3);
    check_val("t5_frames", 32'(m_frames), 32'd6);
    read_frame(1'b0, 2, 8'h51, "t5_rd");
    idle(70);
    check_val("t5_nothing_more", 32'(m_rready), 32'd0);

    // overflow on the 16-entry instance, then recovery
    ov_seen = 0;
    send_frame(1'b1, 20, 8'h61, 1'b0, 1'b1);
    tick();
    check_val("t4_ovf_pulses", 32'(ov_seen), 32'd1);
    check_val("t4_not_ready", 32'(s_rready), 32'd0);
    check_val("t4_drops", 32'(s_drops), 32'd1);
    send_frame(1'b1, 3, 8'h71, 1'b0, 1'b1);
    check_val("t4_commit", 32'(s_rready), 32'd1);
    read_frame(1'b1, 3, 8'h71, "t4_rd");
    check_val("t4_frames", 32'(s_frames), 32'd1);
    ov_seen = 0;
    send_frame(1'b1, 13, 8'h01, 1'b0, 1'b1);
    tick();
    check_val("t4_long_drops", 32'(s_drops), 32'd2);
    check_val("t4_long_no_ovf", 32'(ov_seen), 32'd0);
    idle(10);
    check_val("t4_long_not_ready", 32'(s_rready), 32'd0);

    // reset in the middle of reading a committed frame
    send_frame(1'b0, 8, 8'h81, 1'b0, 1'b1);
    check_val("t6_ready", 32'(m_rready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_val("t6_rd_pre", {24'd0, m_rdata}, 32'(8'h81 + i));
      m_rreq = 1'b1;
      tick();
    end
    m_rreq = 1'b0;
    #2 i_rst_n = 1'b0;
    #1 check_val("t6_ready_in_reset", 32'(m_rready), 32'd0);
    idle(2);
    i_rst_n = 1'b1;
    idle(2);
    check_val("t6_frames_cleared", 32'(m_frames), 32'd0);
    check_val("t6_drops_cleared", 32'(m_drops), 32'd0);
    check_val("t6_empty", 32'(m_rready), 32'd0);
    send_frame(1'b0, 3, 8'h91, 1'b0, 1'b1);
    read_frame(1'b0, 3, 8'h91, "t6_rd");
    check_val("t6_frames", 32'(m_frames), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
